// File: rtl/jtdd_sdram_arb.sv
// jtdd_sdram_arb: read-side SDRAM arbiter for the Double Dragon ROM requesters.
// Four slots (main, MCU, char, obj), each with a one-word tagged cache.
// Fixed priority 0 > 1 > 2 > 3, one outstanding request at a time.
module jtdd_sdram_arb #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,

  input  logic          slot0_cs,
  input  logic [AW-1:0] slot0_addr,
  output logic          slot0_ok,
  output logic [31:0]   slot0_dout,

  input  logic          slot1_cs,
  input  logic [AW-1:0] slot1_addr,
  output logic          slot1_ok,
  output logic [31:0]   slot1_dout,

  input  logic          slot2_cs,
  input  logic [AW-1:0] slot2_addr,
  output logic          slot2_ok,
  output logic [31:0]   slot2_dout,

  input  logic          slot3_cs,
  input  logic [AW-1:0] slot3_addr,
  output logic          slot3_ok,
  output logic [31:0]   slot3_dout,

  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [31:0]   data_read,
  output logic          refresh_en
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state;
  logic [1:0]    sel;
  logic [3:0]    valid;
  logic [AW-1:0] tag    [4];
  logic [31:0]   data   [4];

  logic [3:0]    cs_v;
  logic [AW-1:0] addr_v [4];
  logic [3:0]    hit;
  logic [3:0]    miss;
  logic          any_miss;
  logic [1:0]    pick;

  assign cs_v      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign addr_v[0] = slot0_addr;
  assign addr_v[1] = slot1_addr;
  assign addr_v[2] = slot2_addr;
  assign addr_v[3] = slot3_addr;

  // Cache lookup per slot and fixed-priority selection of the first miss
  always_comb begin
    hit  = '0;
    miss = '0;
    pick = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      hit[i]  = valid[i] & (tag[i] == addr_v[i]);
      miss[i] = cs_v[i] & ~hit[i];
    end
    for (int unsigned i = 4; i > 0; i--) begin
      if (miss[i-1]) pick = 2'(i-1);
    end
  end

  assign any_miss   = |miss;
  assign refresh_en = (state == IDLE) & ~any_miss & ~downloading;

  assign slot0_ok   = cs_v[0] & hit[0] & ~downloading;
  assign slot1_ok   = cs_v[1] & hit[1] & ~downloading;
  assign slot2_ok   = cs_v[2] & hit[2] & ~downloading;
  assign slot3_ok   = cs_v[3] & hit[3] & ~downloading;
  assign slot0_dout = data[0];
  assign slot1_dout = data[1];
  assign slot2_dout = data[2];
  assign slot3_dout = data[3];

  // Arbitration FSM and cache fill; the tag comes from the latched request
  // address so a slot that moved on mid-request simply misses again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      valid      <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (downloading) begin
      state     <= IDLE;
      sdram_req <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_miss) begin
            sel        <= pick;
            sdram_addr <= addr_v[pick];
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              data[sel]  <= data_read;
              tag[sel]   <= sdram_addr;
              valid[sel] <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_rdy) begin
            data[sel]  <= data_read;
            tag[sel]   <= sdram_addr;
            valid[sel] <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jtdd_sdram_arb.md
# jtdd_sdram_arb

Read-side SDRAM arbiter for the Double Dragon core: shares the single SDRAM read port among four ROM requesters (main CPU, MCU, characters, objects). Each requester gets a one-word tagged cache, so a repeated access completes with no SDRAM traffic. The block sits between the game's ROM address generators and the framework SDRAM controller. It also drives `refresh_en`, holds off all requests during ROM download, and flushes every cache at the end of a download.

## Interface
- `AW`, default 22: SDRAM word-address width (16-bit words).
- `clk`  in  1: system clock, 48 MHz.
- `rst`  in  1: asynchronous, active-high reset.
- `downloading`  in  1: ROM download in progress.
- `slotN_cs`  in  1, N=0..3: slot N requests data (0 = main, 1 = MCU, 2 = char, 3 = obj).
- `slotN_addr`  in  AW: SDRAM word address for slot N, with the offset already applied.
- `slotN_ok`  out  1: `slotN_dout` is valid for the current `slotN_addr`.
- `slotN_dout`  out  32: last word fetched for slot N (words addr and addr+1).
- `sdram_req`  out  1: read request to the SDRAM controller.
- `sdram_addr`  out  AW: address of the request.
- `sdram_ack`  in  1: one-cycle pulse, request accepted.
- `data_rdy`  in  1: one-cycle pulse, `data_read` is valid.
- `data_read`  in  32: SDRAM read data.
- `refresh_en`  out  1: controller may insert a refresh.

## Operation
- Each slot holds: `tag[AW-1:0]`, `valid`, and `data[31:0]`, which drives `slotN_dout`.
- Hit: `hitN = valid_N & (tag_N == slotN_addr)`. This is combinational.
- `slotN_ok = slotN_cs & hitN & ~downloading`. This is combinational, so it drops in the same cycle the address changes.
- Miss: `slotN_cs & ~hitN`.
- The FSM has three states: IDLE, REQ, WAIT.
- IDLE:
  - Pick the lowest-numbered slot that misses, using fixed priority 0 > 1 > 2 > 3.
  - Register its slot id and address into `sdram_addr`, set `sdram_req <= 1`, and go to REQ.
  - If no slot misses, stay in IDLE.
- REQ:
  - On `sdram_ack`, set `sdram_req <= 0` and go to WAIT.
  - If `sdram_ack` and `data_rdy` arrive in the same cycle, complete as WAIT would and go to IDLE.
- WAIT:
  - On `data_rdy`, write `data_read` into the latched slot's data, write the latched address into its tag, set `valid <= 1`, and go to IDLE.
- The latched address is the one stored, even if the slot's `addr` or `cs` changed while the request was in flight. If the new address differs, the slot misses again and is re-requested from IDLE.
- A slot dropping `cs` mid-request does not cancel the SDRAM transaction.
- `refresh_en = (state == IDLE) & ~any_miss`. It is combinational.
- While `downloading = 1`:
  - FSM is forced to IDLE; `sdram_req = 0`; all `valid` bits are cleared every cycle.
  - `refresh_en = 0`; the downloader owns the SDRAM.
  - An in-flight transaction is abandoned, and a later `data_rdy` is ignored.
- `sdram_addr` holds its value outside REQ.

## Timing
- Reset values:
  - state IDLE, `sdram_req` 0, `sdram_addr` 0.
  - all `valid` 0, all tags 0, all `slotN_dout` 0, all `slotN_ok` 0.
  - `refresh_en` is 1 when no `cs` is active.
- Hit latency is 0 cycles: `ok` is high in the same cycle that `cs` and `addr` match.
- Miss path:
  - miss seen in IDLE at cycle t;
  - `sdram_req` high at t+1;
  - `ack` at t+1+a drops `req` at t+2+a;
  - `data_rdy` at cycle r; `slotN_ok` and `dout` valid at r+1.
- At most one outstanding SDRAM request.
- After `data_rdy`, the FSM is back in IDLE the next cycle; a new request can be issued 2 cycles after `data_rdy`.
- Starvation is acceptable: slot 3 is served only when slots 0–2 all hit or are idle.
- A `downloading` falling edge takes effect the next cycle; with all caches invalid, the first active `cs` misses.

## Test plan
- Reset, then `slot0_cs=1`, `addr=0x12345`; SDRAM model returns `ack` 2 cycles after `req` and `data_rdy` 5 cycles after `ack` with 0xDEADBEEF -> exactly one `req` with `sdram_addr=0x12345`; `slot0_ok=1` and `dout=0xDEADBEEF` one cycle after `data_rdy`; re-asserting the same address gives `ok` with no new `req`.
- Slots 1 and 3 both miss in the same cycle (addresses 0x100 and 0x300) -> slot 1 is served first, then slot 3; two `req`s in that order; both `ok`.
- Slot 2 changes `addr` from 0x200 to 0x204 while in WAIT -> the data is stored with tag 0x200; `slot2_ok` stays 0; a second `req` to 0x204 follows; `ok` after it completes.
- `sdram_ack` and `data_rdy` asserted in the same cycle -> the transaction completes; the FSM is in IDLE the next cycle; `ok` is high.
- `downloading` raised during WAIT -> `req=0`, `refresh_en=0`, and a later `data_rdy` is ignored; after `downloading` falls, `slot0_cs` at a previously cached address misses and issues a new `req`.
- Async `rst` pulse mid-REQ -> `sdram_req` goes low immediately, without waiting for a clock edge; all `ok` are 0; normal operation resumes after release.
